// File: rtl/packet_buffer_reader.sv
// packet_buffer_reader: BRAM read initiator feeding a FWFT skid FIFO.
// Optional running XOR checksum on csum: define PACKET_READER_CSUM_EN.
module packet_buffer_reader #(
   parameter int RAM_SIZE     = 32,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4,
   parameter int BYTE_LEN     = 8,
   localparam int AW = $clog2(RAM_SIZE)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [AW-1:0]       start_addr,
   input  logic [AW:0]         len,
   output logic                busy,
   output logic                read_req,
   output logic [AW-1:0]       read_addr,
   input  logic                read_ready,
   input  logic [BYTE_LEN-1:0] read_out,
   output logic                out_valid,
   output logic [BYTE_LEN-1:0] out_data,
   output logic                out_last,
   input  logic                out_ready,
   output logic                done,
   output logic [BYTE_LEN-1:0] csum
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0))
   begin : g_depth_chk
      $error("FIFO_DEPTH must be a power of 2 and >= 2");
   end

   if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_lat_chk
      $warning("FIFO_DEPTH < READ_LATENCY+1 limits throughput");
   end

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

   state_t              state;
   logic [AW:0]         len_q;
   logic [AW:0]         rem;
   logic [AW:0]         delivered;
   logic [CW-1:0]       outstanding;
   logic [CW-1:0]       fifo_count;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [BYTE_LEN-1:0] mem [FIFO_DEPTH];

   logic                accept;
   logic                push;
   logic                pop;
   logic [CW-1:0]       out_n;
   logic [CW-1:0]       cnt_n;
   logic [AW:0]         rem_n;
   logic [CW:0]         credit_sum;
   logic                can_req;
   logic [AW-1:0]       next_addr;

   assign accept    = (state == IDLE) && start;
   // A response with nothing in flight is left over from before a reset.
   assign push      = read_ready && (outstanding != '0);
   assign out_valid = (fifo_count != '0);
   assign out_data  = mem[rd_ptr];
   assign pop       = out_valid && out_ready;
   assign out_last  = out_valid &&
                      ((delivered + (AW+1)'(1)) == len_q);

   assign out_n      = outstanding + CW'(read_req) - CW'(push);
   assign cnt_n      = fifo_count + CW'(push) - CW'(pop);
   assign rem_n      = rem - (AW+1)'(read_req);
   assign credit_sum = {1'b0, out_n} + {1'b0, cnt_n};
   // Request next cycle only if the byte is guaranteed a FIFO slot.
   assign can_req    = (rem_n != '0) &&
                       (credit_sum < (CW+1)'(FIFO_DEPTH));
   assign next_addr  = (read_addr == AW'(RAM_SIZE - 1)) ?
                       '0 : read_addr + AW'(1);

   // Command sequencing, request issue and registered status.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         read_req  <= 1'b0;
         read_addr <= '0;
         rem       <= '0;
         len_q     <= '0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  len_q     <= len;
                  rem       <= len;
                  read_addr <= start_addr;
                  if (len != '0) begin
                     state    <= FETCH;
                     busy     <= 1'b1;
                     read_req <= 1'b1;
                  end else begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (read_req) begin
                  read_addr <= next_addr;
                  rem       <= rem_n;
               end
               read_req <= can_req;
               if (read_req && (rem_n == '0))
                  state <= DRAIN;
            end
            DRAIN: begin
               if (pop && out_last) begin
                  state <= FINISH;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reads issued to the BRAM whose data has not yet returned.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) outstanding <= '0;
      else        outstanding <= out_n;
   end

   // FWFT skid FIFO; head entry drives the output stream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= read_out;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         fifo_count <= cnt_n;
      end
   end

   // Bytes handed downstream for the current command.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      delivered <= '0;
      else if (accept) delivered <= '0;
      else if (pop)    delivered <= delivered + (AW+1)'(1);
   end

`ifdef PACKET_READER_CSUM_EN
   // Running XOR of every accepted stream byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      csum <= '0;
      else if (accept) csum <= '0;
      else if (pop)    csum <= csum ^ out_data;
   end
`else
   assign csum = '0;
`endif

endmodule

// File: tb/tb_packet_buffer_reader.sv
// tb_packet_buffer_reader: table-driven and random commands
// against a queue-based model of the expected byte stream.
module tb_packet_buffer_reader;

   localparam int RS = 32;
   localparam int L  = 2;
   localparam int D  = 4;
   localparam int AW = 5;
   localparam int MAXK = 400;

   typedef struct {
      string name;
      int    addr;
      int    len;
      int    mode;
      int    re_k;
      int    exp_fv;
   } cmd_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   len;
   logic          busy;
   logic          read_req;
   logic [AW-1:0] read_addr;
   logic          read_ready;
   logic [7:0]    read_out;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_last;
   logic          out_ready;
   logic          done;
   logic [7:0]    csum;

   logic [7:0]    ram [RS];
   logic [L-1:0]  pv = '0;
   logic [7:0]    pd [L];
   logic          inj = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   packet_buffer_reader #(
      .RAM_SIZE     (RS),
      .READ_LATENCY (L),
      .FIFO_DEPTH   (D),
      .BYTE_LEN     (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .len        (len),
      .busy       (busy),
      .read_req   (read_req),
      .read_addr  (read_addr),
      .read_ready (read_ready),
      .read_out   (read_out),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .done       (done),
      .csum       (csum)
   );

   // BRAM model: fixed-latency delay line, never reset.
   always @(posedge clk) begin
      pv    <= {pv[L-2:0], read_req};
      pd[0] <= ram[read_addr];
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
   end
   assign read_ready = pv[L-1] | inj;
   assign read_out   = inj ? 8'h5A : pd[L-1];

   task automatic check(input string nm, input int act,
                        input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic run_cmd(input cmd_t c);
      logic [7:0]    got [$];
      logic [AW-1:0] adr [$];
      logic [7:0]    x;
      logic [7:0]    pdt;
      logic          plt;
      logic          pst;
      logic [7:0]    cs_done;
      int k, first_v, done_k, last_k, last_idx;
      int dones, lasts, reqs, hs, viol, over;
      int busy_n, busy1, busy_d, errs, aerr, exp_cs;
      first_v = -1; done_k = -1; last_k = -1; last_idx = -1;
      dones = 0; lasts = 0; reqs = 0; hs = 0; viol = 0;
      over = 0; busy_n = 0; busy1 = 0; busy_d = 0;
      pst = 1'b0; pdt = '0; plt = 1'b0; cs_done = '0;
      @(negedge clk);
      start      = 1'b1;
      start_addr = AW'(c.addr);
      len        = (AW+1)'(c.len);
      out_ready  = 1'b1;
      for (k = 1; k <= MAXK; k++) begin
         @(negedge clk);
         start = 1'b0;
         case (c.mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = !(k >= 3 && k <= 9);
            default: out_ready = 1'b1;
         endcase
         if (pst && !(out_valid && out_data == pdt &&
                      out_last == plt))
            viol++;
         pst = out_valid && !out_ready;
         pdt = out_data;
         plt = out_last;
         if (busy) busy_n++;
         if (k == 1) busy1 = int'(busy);
         if (read_req) begin
            reqs++;
            adr.push_back(read_addr);
         end
         if (reqs - hs > D) over++;
         if (out_valid && first_v < 0) first_v = k;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            hs++;
            last_k = k;
            if (out_last) begin
               lasts++;
               last_idx = got.size();
            end
         end
         if (done) begin
            dones++;
            if (done_k < 0) begin
               done_k  = k;
               cs_done = csum;
               busy_d  = int'(busy);
               if (c.re_k < 0) begin
                  start      = 1'b1;
                  start_addr = '0;
                  len        = (AW+1)'(8);
               end
            end
         end
         if (c.re_k > 0 && k == c.re_k) begin
            start      = 1'b1;
            start_addr = '0;
            len        = (AW+1)'(8);
         end
         if (done_k > 0 && k >= done_k + 2) break;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      errs = 0;
      aerr = 0;
      x    = '0;
      for (int i = 0; i < c.len; i++) begin
         x ^= ram[(c.addr + i) % RS];
         if (i < got.size() &&
             got[i] != ram[(c.addr + i) % RS])
            errs++;
         if (i < adr.size() &&
             int'(adr[i]) != (c.addr + i) % RS)
            aerr++;
      end
`ifdef PACKET_READER_CSUM_EN
      exp_cs = int'(x);
`else
      exp_cs = 0;
`endif
      check($sformatf("%s done_cnt", c.name), dones, 1);
      check($sformatf("%s bytes", c.name), got.size(), c.len);
      check($sformatf("%s data", c.name), errs, 0);
      check($sformatf("%s reqs", c.name), adr.size(), c.len);
      check($sformatf("%s addrs", c.name), aerr, 0);
      check($sformatf("%s lasts", c.name), lasts,
            (c.len != 0) ? 1 : 0);
      check($sformatf("%s stable", c.name), viol, 0);
      check($sformatf("%s credit", c.name), over, 0);
      check($sformatf("%s csum", c.name), int'(cs_done),
            exp_cs);
      check($sformatf("%s busy_at_done", c.name), busy_d, 0);
      if (c.exp_fv >= 0)
         check($sformatf("%s first_valid", c.name), first_v,
               c.exp_fv);
      if (c.len == 0) begin
         check($sformatf("%s busy_cnt", c.name), busy_n, 0);
      end else begin
         check($sformatf("%s last_pos", c.name), last_idx,
               c.len);
         check($sformatf("%s done_gap", c.name),
               done_k - last_k, 1);
         check($sformatf("%s busy_k1", c.name), busy1, 1);
      end
   endtask

   task automatic reset_mid_stream();
      int hs, vcnt;
      hs = 0;
      vcnt = 0;
      @(negedge clk);
      start      = 1'b1;
      start_addr = AW'(16);
      len        = (AW+1)'(8);
      out_ready  = 1'b1;
      for (int k = 1; k <= 50 && hs < 2; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid && out_ready) hs++;
      end
      check("rst hs_before", hs, 2);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst busy", int'(busy), 0);
      check("rst out_valid", int'(out_valid), 0);
      check("rst read_req", int'(read_req), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      inj = 1'b1;
      @(negedge clk);
      inj = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid || busy || done) vcnt++;
      end
      check("rst stray_ignored", vcnt, 0);
   endtask

   cmd_t tbl [8];
   cmd_t c;

   initial begin
      for (int i = 0; i < RS; i++) ram[i] = 8'($urandom);
      ram[16] = 8'hA0;
      ram[17] = 8'hA1;
      ram[18] = 8'hA2;
      ram[19] = 8'hA3;

      tbl[0] = '{"basic",   16,  4, 0,  0,  4};
      tbl[1] = '{"bp4",     16,  4, 2,  0,  4};
      tbl[2] = '{"bp8",     16,  8, 2,  0,  4};
      tbl[3] = '{"wrap",    30,  4, 0,  0,  4};
      tbl[4] = '{"zero",     5,  0, 0,  0, -1};
      tbl[5] = '{"re_busy", 16,  4, 0,  2,  4};
      tbl[6] = '{"re_fin",   3,  5, 0, -1,  4};
      tbl[7] = '{"full",     7, 32, 1,  0, -1};

      reset      = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      len        = '0;
      out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", int'(busy), 0);
      check("reset read_req", int'(read_req), 0);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_last", int'(out_last), 0);
      check("reset done", int'(done), 0);
      check("reset csum", int'(csum), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 8; t++) run_cmd(tbl[t]);

      reset_mid_stream();
      c = '{"after_rst", 9, 1, 0, 0, 4};
      run_cmd(c);

      for (int r = 0; r < 8; r++) begin
         c.name   = $sformatf("rand%0d", r);
         c.addr   = $urandom_range(0, RS - 1);
         c.len    = $urandom_range(0, RS);
         c.mode   = 1;
         c.re_k   = 0;
         c.exp_fv = -1;
         run_cmd(c);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
